alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of cycles operands are held on the ALU before the result is captured (legal 1-15).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 Port: req0_ready / req1_ready  output  1  arbiter accepts the operation this cycle.
REQ-006 Port: req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 Port: req0_op / req1_op  input  5  ALU control code.
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  response available.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester takes the response.
REQ-010 Port: rsp0_result / rsp1_result  output  64  captured ALU result.
REQ-011 Port: rsp0_flags / rsp1_flags  output  4  captured {V,C,Z,N}.
REQ-012 Port: rsp0_err / rsp1_err  output  1  op code was illegal.
REQ-013 Port: alu_a, alu_b  output  32  operands to the shared ALU.
REQ-014 Port: alu_ctrl  output  5  ALU control code to the shared ALU.
REQ-015 Port: alu_result  input  64  ALU result.
REQ-016 Port: alu_flags  input  4  ALU {V,C,Z,N}.
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-019 In IDLE, the arbiter SHALL assert req_ready combinationally only for the granted requester, and only when that requester's valid is high.
REQ-020 Grant SHALL be round-robin: if both requesters are valid, the one not served last is granted; if only one is valid, that one is granted.
REQ-021 The last-served pointer SHALL update only on acceptance.
REQ-022 On acceptance (valid & ready), the arbiter SHALL latch a, b, op and the requester ID, load the latency counter with ALU_LAT-1, and go to EXEC.
REQ-023 In EXEC, alu_a, alu_b and alu_ctrl SHALL be driven from the latched registers and held stable.
REQ-024 In EXEC, the counter SHALL decrement each cycle; when the counter is 0, alu_result and alu_flags SHALL be captured at that clock edge and the FSM SHALL go to RESP.
REQ-025 For ALU_LAT=1, EXEC SHALL last exactly 1 cycle.
REQ-026 Legal op codes SHALL be 5'b00000-5'b01110, 5'b10000 and 5'b10001; all other codes are illegal.
REQ-027 An illegal op SHALL still pass through EXEC, but SHALL capture result=0, flags=0 and err=1.
REQ-028 In RESP, only the latched requester's rsp_valid SHALL be high, with result, flags and err stable until its rsp_ready is seen.
REQ-029 When rsp_valid & rsp_ready, the FSM SHALL go to IDLE at that edge.
REQ-030 A new acceptance SHALL be possible no earlier than the following cycle.
REQ-031 Minimum occupancy per operation SHALL be ALU_LAT+2 cycles.
REQ-032 In IDLE and RESP, alu_a, alu_b and alu_ctrl SHALL be driven to 0.
REQ-033 The non-selected rsp_* outputs SHALL be 0 at all times.
REQ-034 Requests arriving while busy SHALL wait: req_ready stays low and no operand is sampled.
REQ-035 If a requester drops valid before being granted, no operation SHALL be recorded for it.
REQ-036 Simultaneous first requests after reset SHALL grant req0 (pointer resets to "last served = 1").

Reset
REQ-037 When rst_n is low, the block SHALL asynchronously force state to IDLE, all operand/op/result/flag/err registers to 0, counter to 0 and pointer to 1.
REQ-038 During reset, all outputs SHALL be 0.
REQ-039 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no response emitted after release.
REQ-040 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge at which rst_n is high.

Verification
REQ-041 Single op: req0 a=5, b=3, op=00000, ALU_LAT=1, rsp0_ready high -> EXEC 1 cycle; rsp0_valid on the 2nd cycle after acceptance with result=64'h8, err=0; busy falls next cycle.
REQ-042 Contention: both valid continuously, ALU_LAT=1 -> grants alternate req0, req1, req0, req1; each op occupies 3 cycles; responses appear only on the matching rsp port.
REQ-043 Backpressure: rsp1_ready low for 5 cycles -> rsp1_valid, result and flags held constant for those cycles; req0 not accepted until a cycle after rsp1_ready rises.
REQ-044 Latency: ALU_LAT=4, op=00010 with a=32'hFFFF_FFFF, b=2 -> alu_* stable for 4 cycles; result=64'h1_FFFF_FFFE.
REQ-045 Illegal op: op=5'b01111 -> rsp_err=1, result=0, flags=0; the following legal op returns err=0.
REQ-046 Reset mid-op: assert rst_n low during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next simultaneous request grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, externally built ALU.
// Each operation is held on the ALU for ALU_LAT cycles and then returned to its requester.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_result,
    output logic [3:0]  rsp0_flags,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_result,
    output logic [3:0]  rsp1_flags,
    output logic        rsp1_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;

    logic        grant_id;
    logic        grant0;
    logic        grant1;
    logic        rsp_ready_sel;

    function automatic logic op_legal(input logic [4:0] op);
        return (op <= 5'd14) || (op == 5'd16) || (op == 5'd17);
    endfunction

    // Ready is gated by rst_n so that every output reads 0 while reset is held.
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        grant0   = rst_n && (state_q == IDLE) && req0_valid && !grant_id;
        grant1   = rst_n && (state_q == IDLE) && req1_valid && grant_id;
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign rsp_ready_sel = id_q ? rsp1_ready : rsp0_ready;

    // NOTE: every *_d gets its hold value first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    op_d    = grant1 ? req1_op : req0_op;
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = LAT_M1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    if (op_legal(op_q)) begin
                        result_d = alu_result;
                        flags_d  = alu_flags;
                        err_d    = 1'b0;
                    end else begin
                        result_d = 64'd0;
                        flags_d  = 4'd0;
                        err_d    = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 5'd0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 4'd0;
            result_q <= 64'd0;
            flags_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        alu_a       = (state_q == EXEC) ? a_q  : 32'd0;
        alu_b       = (state_q == EXEC) ? b_q  : 32'd0;
        alu_ctrl    = (state_q == EXEC) ? op_q : 5'd0;
        rsp0_valid  = (state_q == RESP) && !id_q;
        rsp1_valid  = (state_q == RESP) && id_q;
        rsp0_result = rsp0_valid ? result_q : 64'd0;
        rsp0_flags  = rsp0_valid ? flags_q  : 4'd0;
        rsp0_err    = rsp0_valid ? err_q    : 1'b0;
        rsp1_result = rsp1_valid ? result_q : 64'd0;
        rsp1_flags  = rsp1_valid ? flags_q  : 4'd0;
        rsp1_err    = rsp1_valid ? err_q    : 1'b0;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=4,
// each fed by a tiny stand-in ALU.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ALU_LAT=1 instance
    logic        r0v, r1v, s0r, s1r;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [4:0]  r0op, r1op;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
    logic [63:0] rsp0_result, rsp1_result, alu_result;
    logic [3:0]  rsp0_flags, rsp1_flags, alu_flags;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_ctrl;

    // ALU_LAT=4 instance
    logic        l_r0v;
    logic [31:0] l_r0a, l_r0b;
    logic [4:0]  l_r0op;
    logic        l_req0_ready, l_req1_ready, l_rsp0_valid, l_rsp1_valid, l_rsp0_err, l_rsp1_err, l_busy;
    logic [63:0] l_rsp0_result, l_rsp1_result, l_alu_result;
    logic [3:0]  l_rsp0_flags, l_rsp1_flags, l_alu_flags;
    logic [31:0] l_alu_a, l_alu_b;
    logic [4:0]  l_alu_ctrl;

    int checks = 0;
    int errors = 0;

    // Stand-in ALU: 0 add, 1 sub, 2 multiply; any other code returns {a,b} with all flags set.
    function automatic logic [63:0] stub_res(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        case (op)
            5'd0:    return {32'd0, a} + {32'd0, b};
            5'd1:    return {32'd0, a - b};
            5'd2:    return {32'd0, a} * {32'd0, b};
            default: return {a, b};
        endcase
    endfunction

    function automatic logic [3:0] stub_flags(input logic [63:0] res, input logic [4:0] op);
        if (op > 5'd2) return 4'hF;
        return {1'b0, res[32], res == 64'd0, res[31]};
    endfunction

    assign alu_result   = stub_res(alu_a, alu_b, alu_ctrl);
    assign alu_flags    = stub_flags(alu_result, alu_ctrl);
    assign l_alu_result = stub_res(l_alu_a, l_alu_b, l_alu_ctrl);
    assign l_alu_flags  = stub_flags(l_alu_result, l_alu_ctrl);

    alu_arbiter #(.ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(s0r), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(s1r), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy)
    );

    alu_arbiter #(.ALU_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l_r0v), .req0_ready(l_req0_ready), .req0_a(l_r0a), .req0_b(l_r0b), .req0_op(l_r0op),
        .req1_valid(1'b0), .req1_ready(l_req1_ready), .req1_a(32'd0), .req1_b(32'd0), .req1_op(5'd0),
        .rsp0_valid(l_rsp0_valid), .rsp0_ready(1'b1), .rsp0_result(l_rsp0_result), .rsp0_flags(l_rsp0_flags), .rsp0_err(l_rsp0_err),
        .rsp1_valid(l_rsp1_valid), .rsp1_ready(1'b0), .rsp1_result(l_rsp1_result), .rsp1_flags(l_rsp1_flags), .rsp1_err(l_rsp1_err),
        .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_ctrl(l_alu_ctrl), .alu_result(l_alu_result), .alu_flags(l_alu_flags),
        .busy(l_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete operation on port 0 with rsp0_ready held high; starts and ends at a negedge in IDLE.
    task automatic run_op0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                           output logic [63:0] res, output logic [3:0] fl, output logic er);
        int n;
        r0v = 1'b1; r0a = a; r0b = b; r0op = op; s0r = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("op_grant", req0_ready, 1);
        @(negedge clk);
        r0v = 1'b0;
        #1;
        n = 0;
        while (!rsp0_valid && n < 20) begin @(negedge clk); #1; n++; end
        check("op_rsp_seen", rsp0_valid, 1);
        res = rsp0_result; fl = rsp0_flags; er = rsp0_err;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic [3:0]  fl;
        logic        er;
    } op_vec_t;

    op_vec_t vecs [7];

    initial begin
        logic [63:0] res;
        logic [3:0]  fl;
        logic        er;
        int          e;

        vecs[0] = '{5'b01111, 32'h12, 32'h34, 64'd0,                   4'h0, 1'b1};
        vecs[1] = '{5'b00000, 32'h2,  32'h2,  64'd4,                   4'h0, 1'b0};
        vecs[2] = '{5'b10000, 32'h12, 32'h34, 64'h0000_0012_0000_0034, 4'hF, 1'b0};
        vecs[3] = '{5'b10001, 32'h12, 32'h34, 64'h0000_0012_0000_0034, 4'hF, 1'b0};
        vecs[4] = '{5'b10010, 32'h12, 32'h34, 64'd0,                   4'h0, 1'b1};
        vecs[5] = '{5'b01110, 32'h12, 32'h34, 64'h0000_0012_0000_0034, 4'hF, 1'b0};
        vecs[6] = '{5'b11111, 32'h12, 32'h34, 64'd0,                   4'h0, 1'b1};

        rst_n = 1'b0;
        r0v = 1'b1; r1v = 1'b1; s0r = 1'b0; s1r = 1'b0;
        r0a = 32'd0; r0b = 32'd0; r0op = 5'd0; r1a = 32'd0; r1b = 32'd0; r1op = 5'd0;
        l_r0v = 1'b1; l_r0a = 32'd0; l_r0b = 32'd0; l_r0op = 5'd0;

        // Reset: outputs all 0 even with requests pending.
        @(negedge clk); @(negedge clk); #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_l_req0_ready", l_req0_ready, 0);

        // Single op, ALU_LAT=1: accept on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1; r1v = 1'b0; l_r0v = 1'b0;
        r0v = 1'b1; r0a = 32'd5; r0b = 32'd3; r0op = 5'd0; s0r = 1'b1;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        check("single_busy_idle", busy, 0);
        @(negedge clk); r0v = 1'b0; #1;
        check("single_exec_busy", busy, 1);
        check("single_exec_alu_a", alu_a, 5);
        check("single_exec_alu_b", alu_b, 3);
        check("single_exec_rsp0", rsp0_valid, 0);
        @(negedge clk); #1;
        check("single_rsp0_valid", rsp0_valid, 1);
        check("single_rsp0_result", rsp0_result, 64'h8);
        check("single_rsp0_err", rsp0_err, 0);
        check("single_rsp1_valid", rsp1_valid, 0);
        check("single_resp_alu_a", alu_a, 0);
        @(negedge clk); #1;
        check("single_busy_fall", busy, 0);
        check("single_rsp0_drop", rsp0_valid, 0);

        // Latency, ALU_LAT=4: operands held for exactly 4 cycles.
        @(negedge clk);
        l_r0v = 1'b1; l_r0a = 32'hFFFF_FFFF; l_r0b = 32'd2; l_r0op = 5'd2;
        #1;
        check("lat_ready0", l_req0_ready, 1);
        @(negedge clk); l_r0v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lat_alu_a", l_alu_a, 32'hFFFF_FFFF);
            check("lat_alu_b", l_alu_b, 2);
            check("lat_alu_ctrl", l_alu_ctrl, 2);
            check("lat_no_rsp", l_rsp0_valid, 0);
            @(negedge clk);
        end
        #1;
        check("lat_rsp_valid", l_rsp0_valid, 1);
        check("lat_result", l_rsp0_result, 64'h1_FFFF_FFFE);
        check("lat_flags", l_rsp0_flags, 4'b0101);
        check("lat_alu_idle", l_alu_a, 0);
        @(negedge clk); #1;
        check("lat_busy_fall", l_busy, 0);

        // Contention: fresh reset so the first grant goes to req0, then strict alternation.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r0v = 1'b1; r0a = 32'd10;  r0b = 32'd1;  r0op = 5'd0;
        r1v = 1'b1; r1a = 32'd100; r1b = 32'd20; r1op = 5'd1;
        s0r = 1'b1; s1r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            #1;
            check("cont_ready0", req0_ready, e == 0);
            check("cont_ready1", req1_ready, e == 1);
            @(negedge clk); #1;
            check("cont_exec_busy", busy, 1);
            check("cont_exec_rsp", {rsp1_valid, rsp0_valid}, 0);
            @(negedge clk); #1;
            check("cont_rsp0_valid", rsp0_valid, e == 0);
            check("cont_rsp1_valid", rsp1_valid, e == 1);
            check("cont_result", (e == 1) ? rsp1_result : rsp0_result, (e == 1) ? 64'd80 : 64'd11);
            check("cont_other_result", (e == 1) ? rsp0_result : rsp1_result, 0);
            @(negedge clk);
        end
        r0v = 1'b0; r1v = 1'b0;

        // Backpressure on rsp1 while req0 waits.
        r1v = 1'b1; r1a = 32'd7; r1b = 32'd9; r1op = 5'd0; s1r = 1'b0;
        #1;
        check("bp_ready1", req1_ready, 1);
        @(negedge clk);
        r1v = 1'b0;
        r0v = 1'b1; r0a = 32'd1; r0b = 32'd1; r0op = 5'd0;
        #1;
        check("bp_exec_ready0", req0_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp1_valid", rsp1_valid, 1);
            check("bp_rsp1_result", rsp1_result, 64'd16);
            check("bp_rsp1_flags", rsp1_flags, 0);
            check("bp_ready0_held", req0_ready, 0);
            check("bp_rsp0_valid", rsp0_valid, 0);
            @(negedge clk);
        end
        s1r = 1'b1;
        #1;
        check("bp_release_ready0", req0_ready, 0);
        check("bp_release_rsp1", rsp1_valid, 1);
        @(negedge clk); #1;
        check("bp_after_rsp1", rsp1_valid, 0);
        check("bp_after_ready0", req0_ready, 1);
        @(negedge clk); r0v = 1'b0;
        @(negedge clk); #1;
        check("bp_req0_rsp", rsp0_valid, 1);
        check("bp_req0_result", rsp0_result, 64'd2);
        @(negedge clk);

        // Op-code legality boundaries, including a legal op right after an illegal one.
        for (int i = 0; i < 7; i++) begin
            run_op0(vecs[i].a, vecs[i].b, vecs[i].op, res, fl, er);
            check($sformatf("op%0d_err", i), er, vecs[i].er);
            check($sformatf("op%0d_result", i), res, vecs[i].res);
            check($sformatf("op%0d_flags", i), fl, vecs[i].fl);
        end

        // Reset mid-EXEC: pointer was just moved to req0, so reset must restore it.
        r0v = 1'b1; r0a = 32'd5; r0b = 32'd3; r0op = 5'd0; s0r = 1'b1; r1v = 1'b0;
        #1;
        check("rmid_ready0", req0_ready, 1);
        @(negedge clk); #1;
        check("rmid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", busy, 0);
        check("rmid_alu_a", alu_a, 0);
        check("rmid_alu_ctrl", alu_ctrl, 0);
        check("rmid_rsp0", rsp0_valid, 0);
        check("rmid_ready0_in_rst", req0_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; r0v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rmid_no_rsp", {rsp1_valid, rsp0_valid}, 0);
            check("rmid_idle", busy, 0);
            @(negedge clk);
        end
        r0v = 1'b1; r1v = 1'b1;
        #1;
        check("rmid_grant0", req0_ready, 1);
        check("rmid_grant1", req1_ready, 0);
        @(negedge clk); r0v = 1'b0; r1v = 1'b0;
        @(negedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
